mms_preempt_sched: RTL and testbench
====================================

// Module: mms_preempt_sched
// PURPOSE
//  Preemption scheduler for the Clause 99 MAC Merge transmit processing state machine.
//  Sits between the express/preemptable MAC queues and the transmit state machine.
//  Drives eTx, pTX, preempt and hold from queue requests, verification status and
//  fragment progress. Enforces the minimum fragment rule and counts preemptions.
// PARAMETERS
//  FRAG_W      11   width of fragment byte counters (matches transmit fragSize)
//  MIN_REMAIN  64   min bytes (incl. FCS) left in a preemptable frame for preempt to be legal
//  CNT_W       16   width of saturating preemption statistics counter
// PORTS
//  clk            in   1      single clock
//  reset_n        in   1      synchronous reset, active low
//  e_req          in   1      express frame pending
//  p_req          in   1      preemptable frame pending
//  preempt_en     in   1      management enable for preemption
//  pActive        in   1      verification complete/active (from verify SM)
//  hold_req       in   1      scheduled-traffic hold request
//  add_frag_size  in   2      addFragSize management value
//  tx_state       in   4      current transmit processing state code
//  frag_size      in   FRAG_W bytes sent in current fragment
//  p_remain       in   FRAG_W bytes (incl. FCS) still to send of current preemptable frame
//  eTx            out  1      express transmit request
//  pTX            out  1      preemptable transmit request
//  preempt        out  1      preempt current preemptable fragment
//  hold           out  1      hold preemptable traffic
//  sched_state    out  3      scheduler state (debug)
//  preempt_cnt    out  CNT_W  count of preemptions performed, saturating
// BEHAVIOUR
//  Reset: all outputs 0, sched_state=S_IDLE, min_frag latch=60. All outputs registered (1-cycle latency).
//  Reset asserted mid-operation: every register returns to its reset value at the next edge. No frame state is kept.
//  gate = preempt_en & pActive; when gate=0, preempt and hold are forced 0 the next cycle.
//  min_frag = 64*(1+add_frag_size)-4 (60/124/188/252); latched on entry to START_PREAMBLE, so changes mid-frame are ignored.
//  States:
//   S_IDLE: eTx=e_req; pTX=p_req & ~e_req (express wins on tie); ->S_EXPRESS when tx_state=EXPRESS_TX;
//           ->S_PTX when tx_state=START_PREAMBLE.
//   S_EXPRESS: eTx held 1 until tx_state=E_TX_COMPLETE, then eTx=e_req;
//           ->S_SUSPEND if tx_state=RESUME_WAIT, else ->S_IDLE when tx_state=IDLE_TX_PROC.
//   S_PTX: preempt set when tx_state=PREEMPTABLE_TX & gate & (e_req|hold_req)
//           & frag_size>=min_frag & p_remain>=MIN_REMAIN; ->S_PREQ on set;
//           ->S_IDLE when tx_state=P_TX_COMPLETE (frame finished).
//   S_PREQ: preempt held 1 until tx_state=TX_MCRC_STATE, then 0; preempt_cnt+1 (saturate at all-ones);
//           ->S_SUSPEND when tx_state=RESUME_WAIT.
//   S_SUSPEND: hold=hold_req & gate; eTx=e_req; ->S_EXPRESS when tx_state=EXPRESS_TX;
//           ->S_PTX when tx_state=RESUME_PREAMBLE.
//  hold outside S_SUSPEND/S_PTX = hold_req & gate; IDLE pTX is suppressed while hold=1.
//  e_req dropping while preempt=1 and mCRC not yet reached: preempt stays 1 (the transmit SM cannot abort).
//  Simultaneous e_req rise and P_TX_COMPLETE: no preempt; go to S_IDLE, express is served next.
//  Illegal/unknown tx_state code: state held, outputs held.
// STRUCTURE
//  Shared include mms_pkg: tx_state codes (INIT_TX_PROC..SEND_FRAG_COUNT, 4-bit),
//   sched state codes S_IDLE..S_SUSPEND, min-frag constants.
//  One sub-module, mms_frag_guard: min_frag latch plus the frag_size/p_remain comparison.
//   Outputs a single frag_ok bit.
// TESTING
//  1 e_req=1,p_req=1 in IDLE -> eTx=1,pTX=0 next cycle; preempt never asserts.
//  2 add_frag_size=0, e_req rises at frag_size=40 -> preempt stays 0 until frag_size=60, then preempt=1 and preempt_cnt=1 after MCRC.
//  3 add_frag_size=2, p_remain=63 at frag_size=200 with e_req=1 -> preempt stays 0; frame completes; S_IDLE.
//  4 pActive=0 and e_req=1 during PREEMPTABLE_TX -> preempt=0 throughout; hold=0 even with hold_req=1.
//  5 add_frag_size changed 0->3 at frag_size=10 -> threshold stays 60 for this frame and is 252 for the next.
//  6 reset_n=0 while in S_PREQ with preempt=1 -> next edge: all outputs 0, preempt_cnt=0, sched_state=S_IDLE.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared definitions for the MAC Merge preemption scheduler: transmit
// processing state codes, scheduler state codes and min-fragment helpers.
package mms_pkg;

  // Transmit processing state machine codes (4-bit, as seen on tx_state)
  typedef enum logic [3:0] {
    INIT_TX_PROC    = 4'd0,
    IDLE_TX_PROC    = 4'd1,
    EXPRESS_TX      = 4'd2,
    E_TX_COMPLETE   = 4'd3,
    START_PREAMBLE  = 4'd4,
    PREEMPTABLE_TX  = 4'd5,
    P_TX_COMPLETE   = 4'd6,
    TX_MCRC_STATE   = 4'd7,
    RESUME_WAIT     = 4'd8,
    RESUME_PREAMBLE = 4'd9,
    SEND_FRAG_COUNT = 4'd10
  } tx_state_e;

  // Highest legal tx_state code; anything above is treated as unknown
  localparam logic [3:0] TX_CODE_MAX = 4'd10;

  // Scheduler states (exported on sched_state for debug)
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXPRESS = 3'd1,
    S_PTX     = 3'd2,
    S_PREQ    = 3'd3,
    S_SUSPEND = 3'd4
  } sched_state_e;

  // Minimum fragment size with addFragSize = 0 (64 bytes minus the 4-byte mCRC)
  localparam logic [7:0] MIN_FRAG_BASE = 8'd60;

  // min_frag = 64*(1+add_frag_size)-4, i.e. 60/124/188/252
  function automatic logic [7:0] min_frag_f(input logic [1:0] add_frag_size);
    return {add_frag_size, 6'b000000} + MIN_FRAG_BASE;
  endfunction

endpackage

// File: rtl/mms_frag_guard.sv
// Minimum fragment guard: latches the min-fragment threshold at frame start
// and reports whether the current preemptable fragment may legally be cut.
module mms_frag_guard
  import mms_pkg::*;
#(
  parameter int unsigned FRAG_W     = 11,
  parameter int unsigned MIN_REMAIN = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              latch_en,
  input  logic [1:0]        add_frag_size,
  input  logic [FRAG_W-1:0] frag_size,
  input  logic [FRAG_W-1:0] p_remain,
  output logic              frag_ok
);

  localparam logic [FRAG_W-1:0] MIN_REMAIN_W = FRAG_W'(MIN_REMAIN);
  localparam logic [FRAG_W-1:0] MIN_FRAG_RST = FRAG_W'(MIN_FRAG_BASE);

  logic [FRAG_W-1:0] min_frag_q;
  logic [FRAG_W-1:0] min_frag_d;

  // Capture addFragSize only at frame start so mid-frame changes are ignored
  always_comb begin
    min_frag_d = min_frag_q;
    if (latch_en) begin
      min_frag_d = FRAG_W'(min_frag_f(add_frag_size));
    end else begin
      min_frag_d = min_frag_q;
    end
  end

  // Threshold register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      min_frag_q <= MIN_FRAG_RST;
    end else begin
      min_frag_q <= min_frag_d;
    end
  end

  // Cutting is legal once enough was sent and enough remains for a valid tail
  assign frag_ok = (frag_size >= min_frag_q) && (p_remain >= MIN_REMAIN_W);

endmodule

// File: rtl/mms_preempt_sched.sv
// Preemption scheduler between the express/preemptable MAC queues and the
// MAC Merge transmit processing state machine. All outputs are registered.
module mms_preempt_sched
  import mms_pkg::*;
#(
  parameter int unsigned FRAG_W     = 11,
  parameter int unsigned MIN_REMAIN = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              e_req,
  input  logic              p_req,
  input  logic              preempt_en,
  input  logic              pActive,
  input  logic              hold_req,
  input  logic [1:0]        add_frag_size,
  input  logic [3:0]        tx_state,
  input  logic [FRAG_W-1:0] frag_size,
  input  logic [FRAG_W-1:0] p_remain,
  output logic              eTx,
  output logic              pTX,
  output logic              preempt,
  output logic              hold,
  output logic [2:0]        sched_state,
  output logic [CNT_W-1:0]  preempt_cnt
);

  sched_state_e     state_q, state_d;
  logic             etx_q, etx_d;
  logic             ptx_q, ptx_d;
  logic             preempt_q, preempt_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_s;
  logic             tx_legal_s;
  logic             latch_s;
  logic             frag_ok_s;
  logic             cnt_inc_s;
  logic             want_preempt_s;

  assign gate_s     = preempt_en & pActive;
  assign tx_legal_s = (tx_state <= TX_CODE_MAX);
  assign latch_s    = (tx_state == START_PREAMBLE);

  mms_frag_guard #(
    .FRAG_W     (FRAG_W),
    .MIN_REMAIN (MIN_REMAIN)
  ) u_frag_guard (
    .clk           (clk),
    .reset_n       (reset_n),
    .latch_en      (latch_s),
    .add_frag_size (add_frag_size),
    .frag_size     (frag_size),
    .p_remain      (p_remain),
    .frag_ok       (frag_ok_s)
  );

  assign want_preempt_s = (tx_state == PREEMPTABLE_TX) & gate_s & (e_req | hold_req) & frag_ok_s;

  // Next scheduler state and next output values; unknown tx_state freezes everything
  always_comb begin
    state_d   = state_q;
    etx_d     = etx_q;
    ptx_d     = ptx_q;
    preempt_d = preempt_q;
    hold_d    = hold_q;
    cnt_inc_s = 1'b0;
    if (tx_legal_s) begin
      etx_d     = 1'b0;
      ptx_d     = 1'b0;
      preempt_d = 1'b0;
      hold_d    = hold_req & gate_s;
      case (state_q)
        S_IDLE: begin
          etx_d = e_req;
          ptx_d = p_req & ~e_req & ~hold_d;
          if (tx_state == EXPRESS_TX) begin
            state_d = S_EXPRESS;
          end else if (tx_state == START_PREAMBLE) begin
            state_d = S_PTX;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXPRESS: begin
          // The express request stays up until the express frame has completed
          if ((tx_state == E_TX_COMPLETE) || (tx_state == IDLE_TX_PROC) ||
              (tx_state == RESUME_WAIT)) begin
            etx_d = e_req;
          end else begin
            etx_d = 1'b1;
          end
          if (tx_state == RESUME_WAIT) begin
            state_d = S_SUSPEND;
          end else if (tx_state == IDLE_TX_PROC) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_EXPRESS;
          end
        end
        S_PTX: begin
          // Preemption itself is the hold mechanism inside a preemptable frame
          hold_d    = 1'b0;
          preempt_d = want_preempt_s;
          if (want_preempt_s) begin
            state_d = S_PREQ;
          end else if (tx_state == P_TX_COMPLETE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PTX;
          end
        end
        S_PREQ: begin
          // Once raised, preempt cannot be withdrawn before the mCRC goes out
          if (tx_state == TX_MCRC_STATE) begin
            preempt_d = 1'b0;
            cnt_inc_s = preempt_q;
          end else begin
            preempt_d = preempt_q;
            cnt_inc_s = 1'b0;
          end
          if (tx_state == RESUME_WAIT) begin
            state_d = S_SUSPEND;
          end else begin
            state_d = S_PREQ;
          end
        end
        S_SUSPEND: begin
          etx_d = e_req;
          if (tx_state == EXPRESS_TX) begin
            state_d = S_EXPRESS;
          end else if (tx_state == RESUME_PREAMBLE) begin
            state_d = S_PTX;
          end else begin
            state_d = S_SUSPEND;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    // Without verified, enabled preemption neither preempt nor hold may be driven
    preempt_d = preempt_d & gate_s;
    hold_d    = hold_d & gate_s;
  end

  // Saturating preemption counter next value
  always_comb begin
    if (cnt_inc_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      etx_q     <= 1'b0;
      ptx_q     <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      etx_q     <= etx_d;
      ptx_q     <= ptx_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
    end
  end

  assign eTx         = etx_q;
  assign pTX         = ptx_q;
  assign preempt     = preempt_q;
  assign hold        = hold_q;
  assign sched_state = state_q;
  assign preempt_cnt = cnt_q;

endmodule

// File: tb/tb_mms_preempt_sched.sv
// Self-checking bench for mms_preempt_sched: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_mms_preempt_sched;
  import mms_pkg::*;

  localparam int TB_FRAG_W = 11;
  localparam int TB_CNT_W  = 3;   // small counter so saturation is reachable
  localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;

  // scheduler state numbering S_IDLE..S_SUSPEND
  localparam int ST_IDLE = 0, ST_EXP = 1, ST_PTX = 2, ST_PREQ = 3, ST_SUSP = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 e_req, p_req, preempt_en, pActive, hold_req;
  logic [1:0]           add_frag_size;
  logic [3:0]           tx_state;
  logic [TB_FRAG_W-1:0] frag_size, p_remain;
  logic                 eTx, pTX, preempt, hold;
  logic [2:0]           sched_state;
  logic [TB_CNT_W-1:0]  preempt_cnt;

  int n_checks;
  int n_errors;

  // model state
  int m_st;
  bit m_etx, m_ptx, m_pre, m_hold;
  int m_cnt;
  int m_min;

  mms_preempt_sched #(
    .FRAG_W     (TB_FRAG_W),
    .MIN_REMAIN (64),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .e_req         (e_req),
    .p_req         (p_req),
    .preempt_en    (preempt_en),
    .pActive       (pActive),
    .hold_req      (hold_req),
    .add_frag_size (add_frag_size),
    .tx_state      (tx_state),
    .frag_size     (frag_size),
    .p_remain      (p_remain),
    .eTx           (eTx),
    .pTX           (pTX),
    .preempt       (preempt),
    .hold          (hold),
    .sched_state   (sched_state),
    .preempt_cnt   (preempt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_etx = 0; m_ptx = 0; m_pre = 0; m_hold = 0; m_cnt = 0; m_min = 60;
  endtask

  // What the scheduler should present after the coming clock edge
  task automatic model_step();
    bit gate, go, nx_etx, nx_ptx, nx_pre, nx_hold;
    int tx, fs, pr;
    gate = preempt_en && pActive;
    tx = int'(tx_state); fs = int'(frag_size); pr = int'(p_remain);
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (tx > 10) begin
      m_pre  = m_pre && gate;
      m_hold = m_hold && gate;
      return;
    end
    nx_etx = 0; nx_ptx = 0; nx_pre = 0;
    nx_hold = hold_req && gate;
    if (m_st == ST_IDLE) begin
      nx_etx = e_req;
      nx_ptx = p_req && !e_req && !nx_hold;
      if (tx == EXPRESS_TX) m_st = ST_EXP;
      else if (tx == START_PREAMBLE) m_st = ST_PTX;
    end else if (m_st == ST_EXP) begin
      nx_etx = (tx == E_TX_COMPLETE || tx == IDLE_TX_PROC || tx == RESUME_WAIT) ? e_req : 1'b1;
      if (tx == RESUME_WAIT) m_st = ST_SUSP;
      else if (tx == IDLE_TX_PROC) m_st = ST_IDLE;
    end else if (m_st == ST_PTX) begin
      nx_hold = 0;
      go = (tx == PREEMPTABLE_TX) && gate && (e_req || hold_req) && (fs >= m_min) && (pr >= 64);
      nx_pre = go;
      if (go) m_st = ST_PREQ;
      else if (tx == P_TX_COMPLETE) m_st = ST_IDLE;
    end else if (m_st == ST_PREQ) begin
      if (tx == TX_MCRC_STATE) begin
        if (m_pre && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        nx_pre = 0;
      end else begin
        nx_pre = m_pre;
      end
      if (tx == RESUME_WAIT) m_st = ST_SUSP;
    end else begin
      nx_etx = e_req;
      if (tx == EXPRESS_TX) m_st = ST_EXP;
      else if (tx == RESUME_PREAMBLE) m_st = ST_PTX;
    end
    m_etx = nx_etx; m_ptx = nx_ptx; m_pre = nx_pre && gate; m_hold = nx_hold;
    if (tx == START_PREAMBLE) m_min = 64 * (1 + int'(add_frag_size)) - 4;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".eTx"}, 32'(eTx), 32'(m_etx));
    chk({tag, ".pTX"}, 32'(pTX), 32'(m_ptx));
    chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
    chk({tag, ".hold"}, 32'(hold), 32'(m_hold));
    chk({tag, ".state"}, 32'(sched_state), 32'(m_st));
    chk({tag, ".cnt"}, 32'(preempt_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model, compare on the falling edge
  task automatic cyc(input logic [3:0] tx, input logic e, input int fs, input int pr);
    tx_state  = tx;
    e_req     = e;
    frag_size = TB_FRAG_W'(fs);
    p_remain  = TB_FRAG_W'(pr);
    model_step();
    @(negedge clk);
    check_all("model");
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; e_req = 1'b0; p_req = 1'b0; preempt_en = 1'b0; pActive = 1'b0;
    hold_req = 1'b0; add_frag_size = 2'd0; tx_state = IDLE_TX_PROC;
    frag_size = '0; p_remain = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset_state", 32'(sched_state), 32'(ST_IDLE));

    reset_n = 1'b1; preempt_en = 1'b1; pActive = 1'b1;

    // 1: express wins a tie in IDLE
    p_req = 1'b1;
    cyc(IDLE_TX_PROC, 1'b1, 0, 0);
    chk("t1_etx", 32'(eTx), 32'd1);
    chk("t1_ptx", 32'(pTX), 32'd0);
    cyc(IDLE_TX_PROC, 1'b1, 0, 0);
    chk("t1_preempt", 32'(preempt), 32'd0);
    cyc(IDLE_TX_PROC, 1'b0, 0, 0);
    chk("t1_ptx_alone", 32'(pTX), 32'd1);

    // 2: minimum fragment 60, preempt after it, count after mCRC
    add_frag_size = 2'd0;
    cyc(START_PREAMBLE, 1'b0, 0, 500);
    chk("t2_in_ptx", 32'(sched_state), 32'(ST_PTX));
    for (int f = 0; f < 40; f += 8) cyc(PREEMPTABLE_TX, 1'b0, f, 500);
    for (int f = 40; f < 60; f += 4) begin
      cyc(PREEMPTABLE_TX, 1'b1, f, 500);
      chk("t2_too_early", 32'(preempt), 32'd0);
    end
    cyc(PREEMPTABLE_TX, 1'b1, 60, 500);
    chk("t2_preempt", 32'(preempt), 32'd1);
    cyc(PREEMPTABLE_TX, 1'b0, 61, 500);
    chk("t2_sticky", 32'(preempt), 32'd1);
    cyc(TX_MCRC_STATE, 1'b0, 62, 500);
    chk("t2_released", 32'(preempt), 32'd0);
    chk("t2_cnt", 32'(preempt_cnt), 32'd1);
    cyc(RESUME_WAIT, 1'b1, 0, 440);
    chk("t2_suspend", 32'(sched_state), 32'(ST_SUSP));
    cyc(EXPRESS_TX, 1'b1, 0, 440);
    cyc(EXPRESS_TX, 1'b0, 0, 440);
    chk("t2_etx_held", 32'(eTx), 32'd1);
    cyc(E_TX_COMPLETE, 1'b0, 0, 440);
    chk("t2_etx_drop", 32'(eTx), 32'd0);
    cyc(RESUME_WAIT, 1'b0, 0, 440);
    cyc(RESUME_PREAMBLE, 1'b0, 0, 440);
    chk("t2_resumed", 32'(sched_state), 32'(ST_PTX));
    cyc(PREEMPTABLE_TX, 1'b0, 10, 100);
    cyc(P_TX_COMPLETE, 1'b0, 0, 0);
    chk("t2_idle", 32'(sched_state), 32'(ST_IDLE));

    // 3: tail shorter than 64 bytes blocks preemption; e_req with frame end
    add_frag_size = 2'd2;
    cyc(START_PREAMBLE, 1'b0, 0, 263);
    cyc(PREEMPTABLE_TX, 1'b1, 200, 63);
    chk("t3_short_tail", 32'(preempt), 32'd0);
    cyc(PREEMPTABLE_TX, 1'b1, 201, 62);
    chk("t3_short_tail2", 32'(preempt), 32'd0);
    cyc(P_TX_COMPLETE, 1'b1, 0, 0);
    chk("t3_no_preempt", 32'(preempt), 32'd0);
    chk("t3_idle", 32'(sched_state), 32'(ST_IDLE));
    cyc(EXPRESS_TX, 1'b1, 0, 0);
    chk("t3_express", 32'(sched_state), 32'(ST_EXP));
    cyc(E_TX_COMPLETE, 1'b0, 0, 0);
    cyc(IDLE_TX_PROC, 1'b0, 0, 0);

    // 4: gate closed -> no preempt, no hold
    add_frag_size = 2'd0; pActive = 1'b0; hold_req = 1'b1;
    cyc(START_PREAMBLE, 1'b0, 0, 300);
    for (int i = 0; i < 4; i++) begin
      cyc(PREEMPTABLE_TX, 1'b1, 100 + i, 100);
      chk("t4_preempt", 32'(preempt), 32'd0);
      chk("t4_hold", 32'(hold), 32'd0);
    end
    cyc(P_TX_COMPLETE, 1'b0, 0, 0);
    cyc(IDLE_TX_PROC, 1'b0, 0, 0);
    chk("t4_hold_idle", 32'(hold), 32'd0);
    pActive = 1'b1;
    cyc(IDLE_TX_PROC, 1'b0, 0, 0);
    chk("t4_hold_open", 32'(hold), 32'd1);
    chk("t4_ptx_held", 32'(pTX), 32'd0);
    hold_req = 1'b0;

    // 5: threshold latched at frame start
    add_frag_size = 2'd0;
    cyc(START_PREAMBLE, 1'b0, 0, 300);
    cyc(PREEMPTABLE_TX, 1'b0, 10, 300);
    add_frag_size = 2'd3;
    cyc(PREEMPTABLE_TX, 1'b0, 30, 300);
    cyc(PREEMPTABLE_TX, 1'b1, 59, 300);
    chk("t5_below60", 32'(preempt), 32'd0);
    cyc(PREEMPTABLE_TX, 1'b1, 60, 300);
    chk("t5_at60", 32'(preempt), 32'd1);
    cyc(TX_MCRC_STATE, 1'b0, 0, 240);
    chk("t5_cnt", 32'(preempt_cnt), 32'd2);
    cyc(RESUME_WAIT, 1'b0, 0, 240);
    cyc(RESUME_PREAMBLE, 1'b0, 0, 240);
    cyc(PREEMPTABLE_TX, 1'b0, 20, 200);
    cyc(P_TX_COMPLETE, 1'b0, 0, 0);
    cyc(START_PREAMBLE, 1'b0, 0, 600);
    cyc(PREEMPTABLE_TX, 1'b1, 251, 300);
    chk("t5_below252", 32'(preempt), 32'd0);
    cyc(PREEMPTABLE_TX, 1'b1, 252, 300);
    chk("t5_at252", 32'(preempt), 32'd1);
    chk("t5_preq", 32'(sched_state), 32'(ST_PREQ));

    // 6: reset while preempting
    reset_n = 1'b0;
    cyc(PREEMPTABLE_TX, 1'b1, 253, 300);
    chk("t6_preempt", 32'(preempt), 32'd0);
    chk("t6_etx", 32'(eTx), 32'd0);
    chk("t6_cnt", 32'(preempt_cnt), 32'd0);
    chk("t6_state", 32'(sched_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset_n       = ($urandom_range(0, 299) != 0);
      preempt_en    = ($urandom_range(0, 9) != 0);
      pActive       = ($urandom_range(0, 9) != 0);
      p_req         = 1'($urandom);
      hold_req      = ($urandom_range(0, 3) == 0);
      add_frag_size = 2'($urandom);
      cyc(4'($urandom_range(0, 15)), 1'($urandom),
          int'($urandom_range(0, 300)), int'($urandom_range(0, 150)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
